spi_tx_scheduler: RTL and testbench

//   Upstream feeder for spi_master. Buffers host bytes in a DEPTH-entry FIFO and

---
 rtl/spi_tx_scheduler.sv | 166 ++++++++++++++++
 tb/tb_spi_tx_scheduler.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_tx_scheduler.sv
// Byte scheduler feeding an SPI master: FIFO-buffers host bytes, launches one
// transfer per byte, captures the returned byte and enforces an idle gap between transfers.
module spi_tx_scheduler #(
    parameter int DEPTH      = 4,
    parameter int AW         = 2,
    parameter int GAP_CYCLES = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    tx_data,
    input  logic          tx_valid,
    output logic          tx_ready,
    output logic [7:0]    rx_data,
    output logic          rx_valid,
    output logic [7:0]    m_data_in,
    output logic          m_start,
    input  logic          m_done,
    input  logic [7:0]    m_data_out,
    output logic          busy,
    output logic [AW:0]   level
);

    localparam int            CW        = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [CW-1:0] GAP_INIT  = CW'(GAP_CYCLES);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [AW:0]   FULL_LVL  = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   LVL_ONE   = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_GAP
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;

    logic [7:0]      r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_level;

    logic            r_m_start;
    logic [7:0]      r_m_data_in;
    logic            r_rx_valid;
    logic [7:0]      r_rx_data;

    logic            w_full;
    logic            w_empty;
    logic            w_push;
    logic            w_pop;
    logic            w_start_nxt;
    logic            w_rxv_nxt;
    logic            w_load_rx;

    assign w_full   = (r_level == FULL_LVL);
    assign w_empty  = (r_level == '0);
    // Full blocks pushes even when a pop lands on the same edge (no pass-through).
    assign tx_ready = !rst && !w_full;
    assign w_push   = tx_valid && tx_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pop       = 1'b0;
        w_start_nxt = 1'b0;
        w_rxv_nxt   = 1'b0;
        w_load_rx   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_start_nxt = 1'b1;
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (m_done) begin
                    w_rxv_nxt = 1'b1;
                    w_load_rx = 1'b1;
                    if (GAP_CYCLES == 0) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_cnt_nxt   = GAP_INIT;
                        w_state_nxt = S_GAP;
                    end
                end
            end
            S_GAP: begin
                w_cnt_nxt = r_cnt - CNT_ONE;
                if (r_cnt <= CNT_ONE) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_m_start   <= 1'b0;
            r_m_data_in <= '0;
            r_rx_valid  <= 1'b0;
            r_rx_data   <= '0;
        end else begin
            r_m_start  <= w_start_nxt;
            r_rx_valid <= w_rxv_nxt;
            if (w_pop) begin
                r_m_data_in <= r_mem[r_rd_ptr];
            end
            if (w_load_rx) begin
                r_rx_data <= m_data_out;
            end
        end
    end

    // Storage carries no reset; occupancy and pointers alone define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= tx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_ONE;
                2'b01:   r_level <= r_level - LVL_ONE;
                default: r_level <= r_level;
            endcase
        end
    end

    assign m_start   = r_m_start;
    assign m_data_in = r_m_data_in;
    assign rx_valid  = r_rx_valid;
    assign rx_data   = r_rx_data;
    assign level     = r_level;
    assign busy      = (r_state != S_IDLE) || !w_empty;

endmodule

// File: tb/tb_spi_tx_scheduler.sv
// Bench for spi_tx_scheduler: queue/timestamp reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_spi_tx_scheduler;

    localparam int DEPTH = 4;
    localparam int AW    = 2;
    localparam int GAP   = 2;

    logic          clk;
    logic          rst;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic [7:0]    m_data_in;
    logic          m_start;
    logic          m_done;
    logic [7:0]    m_data_out;
    logic          busy;
    logic [AW:0]   level;

    spi_tx_scheduler #(.DEPTH(DEPTH), .AW(AW), .GAP_CYCLES(GAP)) dut (
        .clk(clk), .rst(rst),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .m_data_in(m_data_in), .m_start(m_start),
        .m_done(m_done), .m_data_out(m_data_out),
        .busy(busy), .level(level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: FIFO as a queue; transfer timing from "one in flight" and
    // "earliest edge at which the next launch may occur".
    logic [7:0] q[$];
    int         cyc = 0;
    bit         in_flight = 1'b0;
    int         earliest = 0;
    logic       e_start = 1'b0;
    logic [7:0] e_md = '0;
    logic       e_rv = 1'b0;
    logic [7:0] e_rx = '0;
    logic [7:0] start_log[$];

    always @(posedge clk) begin
        int sz;
        sz = q.size();
        cyc++;
        if (rst) begin
            q.delete();
            in_flight = 1'b0;
            earliest  = 0;
            e_start   = 1'b0;
            e_md      = '0;
            e_rv      = 1'b0;
            e_rx      = '0;
        end else begin
            e_start = 1'b0;
            e_rv    = 1'b0;
            if (!in_flight && sz != 0 && cyc >= earliest) begin
                e_md      = q.pop_front();
                e_start   = 1'b1;
                in_flight = 1'b1;
            end else if (in_flight && m_done) begin
                e_rx      = m_data_out;
                e_rv      = 1'b1;
                in_flight = 1'b0;
                earliest  = cyc + GAP + 1;
            end
            if (tx_valid && sz < DEPTH) q.push_back(tx_data);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_start", 32'(m_start), 32'(e_start));
            chk("m_data_in", 32'(m_data_in), 32'(e_md));
            chk("rx_valid", 32'(rx_valid), 32'(e_rv));
            chk("rx_data", 32'(rx_data), 32'(e_rx));
            chk("level", 32'(level), 32'(q.size()));
            chk("tx_ready", 32'(tx_ready), 32'(!rst && q.size() < DEPTH));
            chk("busy", 32'(busy), 32'(in_flight || (cyc < earliest - 1) || q.size() != 0));
            if (m_start === 1'b1) start_log.push_back(m_data_in);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic serve(input logic [7:0] rb, input bit wait_start);
        int n;
        n = 0;
        if (wait_start) begin
            while (m_start !== 1'b1 && n < 50) begin
                tick(1);
                n++;
            end
            chk("start_seen", 32'(m_start), 32'd1);
        end
        tick(2);
        m_data_out = rb;
        m_done = 1'b1;
        tick(1);
        m_done = 1'b0;
    endtask

    task automatic push(input logic [7:0] b);
        int n;
        n = 0;
        tx_data  = b;
        tx_valid = 1'b1;
        while (tx_ready !== 1'b1 && n < 20) begin
            tick(1);
            n++;
        end
        chk("push_ready", 32'(tx_ready), 32'd1);
        tick(1);
        tx_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    logic [7:0] exp2 [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    int t_done;
    int n;

    initial begin
        rst = 1'b1;
        tx_data = '0;
        tx_valid = 1'b0;
        m_done = 1'b0;
        m_data_out = '0;
        tick(1);
        chk_en = 1'b1;
        tick(1);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_m_start", 32'(m_start), 32'd0);
        chk("rst_rx_valid", 32'(rx_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_tx_ready", 32'(tx_ready), 32'd0);
        chk("rst_m_data_in", 32'(m_data_in), 32'd0);
        rst = 1'b0;
        tick(1);

        // Scenario 1: single byte out, single byte back
        tx_data = 8'hEA;
        tx_valid = 1'b1;
        tick(1);
        tx_valid = 1'b0;
        tick(1);
        chk("s1_start", 32'(m_start), 32'd1);
        chk("s1_data", 32'(m_data_in), 32'hEA);
        tick(1);
        chk("s1_start_pulse", 32'(m_start), 32'd0);
        chk("s1_data_held", 32'(m_data_in), 32'hEA);
        tick(1);
        m_data_out = 8'h57;
        m_done = 1'b1;
        tick(1);
        m_done = 1'b0;
        chk("s1_rx_valid", 32'(rx_valid), 32'd1);
        chk("s1_rx_data", 32'(rx_data), 32'h57);
        tick(1);
        chk("s1_rx_valid_once", 32'(rx_valid), 32'd0);
        chk("s1_rx_data_held", 32'(rx_data), 32'h57);
        tick(4);

        // Scenario 2: fill while the master is stalled, then drain in order
        start_log.delete();
        for (int i = 0; i < 5; i++) push(exp2[i]);
        chk("s2_level_full", 32'(level), 32'd4);
        tx_data = 8'h66;
        tx_valid = 1'b1;
        tick(2);
        chk("s2_tx_ready_full", 32'(tx_ready), 32'd0);
        chk("s2_level_held", 32'(level), 32'd4);
        tx_valid = 1'b0;
        for (int i = 0; i < 5; i++) serve(8'hA0 + 8'(i), i > 0);
        tick(4);
        chk("s2_start_count", 32'(start_log.size()), 32'd5);
        for (int i = 0; i < 5; i++)
            chk("s2_order", (i < start_log.size()) ? 32'(start_log[i]) : 32'hFFFF_FFFF, 32'(exp2[i]));

        // Scenarios 3/4: push coinciding with pop at level 1, then gap timing
        start_log.delete();
        tx_data = 8'hB1;
        tx_valid = 1'b1;
        tick(1);
        tx_data = 8'hB2;
        tick(1);
        tx_valid = 1'b0;
        chk("s4_level_same", 32'(level), 32'd1);
        chk("s4_start", 32'(m_start), 32'd1);
        chk("s4_first", 32'(m_data_in), 32'hB1);
        tick(2);
        m_data_out = 8'h3C;
        m_done = 1'b1;
        tick(1);
        t_done = cyc;
        m_done = 1'b0;
        chk("s3_rx_data", 32'(rx_data), 32'h3C);
        n = 0;
        while (m_start !== 1'b1 && n < 20) begin
            tick(1);
            n++;
        end
        chk("s3_gap_edges", 32'(cyc - t_done), 32'd3);
        chk("s4_second", 32'(m_data_in), 32'hB2);
        serve(8'h4D, 1'b1);
        chk("s3_rx2", 32'(rx_data), 32'h4D);
        tick(4);
        chk("s4_count", 32'(start_log.size()), 32'd2);

        // Scenario 5: reset while a transfer is outstanding
        tx_data = 8'hC1;
        tx_valid = 1'b1;
        tick(1);
        tx_data = 8'hC2;
        tick(1);
        tx_valid = 1'b0;
        tick(1);
        chk("s5_busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        tick(1);
        chk("s5_level", 32'(level), 32'd0);
        chk("s5_m_data_in", 32'(m_data_in), 32'd0);
        chk("s5_rx_data", 32'(rx_data), 32'd0);
        chk("s5_busy", 32'(busy), 32'd0);
        chk("s5_tx_ready", 32'(tx_ready), 32'd0);
        rst = 1'b0;
        tick(1);
        m_data_out = 8'hC5;
        m_done = 1'b1;
        tick(1);
        m_done = 1'b0;
        chk("s5_no_rx_valid", 32'(rx_valid), 32'd0);
        tick(2);
        chk("s5_no_restart", 32'(m_start), 32'd0);

        // Scenario 6: stray m_done while idle, then normal operation
        m_data_out = 8'h99;
        m_done = 1'b1;
        tick(1);
        m_done = 1'b0;
        chk("s6_no_rx_valid", 32'(rx_valid), 32'd0);
        chk("s6_busy", 32'(busy), 32'd0);
        tx_data = 8'hD1;
        tx_valid = 1'b1;
        tick(1);
        tx_valid = 1'b0;
        tick(1);
        chk("s6_start", 32'(m_start), 32'd1);
        chk("s6_data", 32'(m_data_in), 32'hD1);
        serve(8'h6E, 1'b1);
        chk("s6_rx_valid", 32'(rx_valid), 32'd1);
        chk("s6_rx_data", 32'(rx_data), 32'h6E);
        tick(4);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
